ddr_burst_sequencer: RTL and testbench

Per-DIMM burst scheduler that sits between command decode and the chip data arrays. It accepts decoded READ/WRITE pulses with rank/bank-group/bank/column, queues them in order, and replays each as a BL-beat data burst exactly CL (read) or CWL (write) cycles later. It drives registered data-path enables, DQS and per-beat column addresses, replacing the combinational `RD || RDA` tristate enable. It also flags command-spacing violations.

---
 rtl/ddr_burst_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_ddr_burst_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_burst_sequencer
// Brief    : Queues decoded READ/WRITE commands and replays each as a BL-beat
//            burst CL/CWL cycles later with registered enables, DQS and column.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_burst_sequencer #(
    parameter int RANKS    = 1,
    parameter int BGWIDTH  = 2,
    parameter int BAWIDTH  = 2,
    parameter int COLWIDTH = 10,
    parameter int BL       = 8,
    parameter int CL       = 16,
    parameter int CWL      = 12,
    parameter int QDEPTH   = 4,
    localparam int RW      = (RANKS > 1) ? $clog2(RANKS) : 1,
    localparam int BLW     = $clog2(BL),
    localparam int QW      = $clog2(QDEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RANKS-1:0]    cs_n,
    input  logic                rd,
    input  logic                wr,
    input  logic [BGWIDTH-1:0]  bg,
    input  logic [BAWIDTH-1:0]  ba,
    input  logic [COLWIDTH-1:0] col,
    output logic                rd_oe,
    output logic                wr_cap,
    output logic [BLW-1:0]      beat,
    output logic                dqs_t_o,
    output logic [RW-1:0]       burst_rank,
    output logic [BGWIDTH-1:0]  burst_bg,
    output logic [BAWIDTH-1:0]  burst_ba,
    output logic [COLWIDTH-1:0] burst_col,
    output logic [QW-1:0]       q_count,
    output logic                busy,
    output logic                overflow,
    output logic                late,
    output logic                cmd_err
);

    localparam int LMAX = (CL > CWL) ? CL : CWL;
    localparam int CDW  = $clog2(LMAX);
    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // ---------------------------------------------------------------- queue
    logic                r_q_wr   [QDEPTH];
    logic [RW-1:0]       r_q_rank [QDEPTH];
    logic [BGWIDTH-1:0]  r_q_bg   [QDEPTH];
    logic [BAWIDTH-1:0]  r_q_ba   [QDEPTH];
    logic [COLWIDTH-1:0] r_q_col  [QDEPTH];
    logic [CDW-1:0]      r_q_cd   [QDEPTH];
    logic [PW-1:0]       r_rptr, r_wptr;
    logic [QW-1:0]       r_count, w_count_nxt;

    logic [0:0]          r_state, w_state_nxt;
    logic [BLW-1:0]      r_beat, w_beat_nxt;
    logic                r_is_wr, w_is_wr_nxt;
    logic [RW-1:0]       r_rank, w_rank_nxt;
    logic [BGWIDTH-1:0]  r_bg, w_bg_nxt;
    logic [BAWIDTH-1:0]  r_ba, w_ba_nxt;
    logic [COLWIDTH-1:0] r_col, w_col_nxt;
    logic [COLWIDTH-1:0] r_bcol, w_bcol_nxt;
    logic                r_rd_oe, r_wr_cap, r_dqs, r_busy;
    logic                w_rd_oe_nxt, w_wr_cap_nxt, w_dqs_nxt, w_busy_nxt, w_burst_nxt;
    logic                r_overflow, r_late, r_cmd_err;

    logic                w_any_low, w_multi_low;
    logic [RW-1:0]       w_rank_idx;
    logic                w_cmd_valid, w_cmd_err;
    logic                w_head_elig, w_last, w_full;
    logic                w_push, w_pop, w_ovf, w_late;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_any_low   = 1'b0;
        w_multi_low = 1'b0;
        w_rank_idx  = '0;
        for (int i = 0; i < RANKS; i++) begin
            if (!cs_n[i]) begin
                if (w_any_low)
                    w_multi_low = 1'b1;
                w_any_low  = 1'b1;
                w_rank_idx = RW'(i);
            end
        end
    end

    assign w_cmd_valid = w_any_low && !w_multi_low && (rd ^ wr);
    assign w_cmd_err   = w_any_low && (rd || wr) && (w_multi_low || (rd && wr));

    assign w_head_elig = (r_count != '0) && (r_q_cd[r_rptr] == '0);
    assign w_last      = (r_beat == BLW'(BL - 1));
    assign w_pop       = w_head_elig && ((r_state == ST_IDLE) || w_last);
    assign w_full      = (r_count == QW'(QDEPTH));
    // A pop on the same edge frees the slot the incoming command needs.
    assign w_push      = w_cmd_valid && (!w_full || w_pop);
    assign w_ovf       = w_cmd_valid && w_full && !w_pop;
    assign w_late      = w_head_elig && (r_state == ST_BURST) && !w_last;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (r_q_cd[i] != '0)
                r_q_cd[i] <= r_q_cd[i] - 1'b1;
        end
        if (w_push) begin
            r_q_wr[r_wptr]   <= wr;
            r_q_rank[r_wptr] <= w_rank_idx;
            r_q_bg[r_wptr]   <= bg;
            r_q_ba[r_wptr]   <= ba;
            r_q_col[r_wptr]  <= col;
            r_q_cd[r_wptr]   <= wr ? CDW'(CWL - 1) : CDW'(CL - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= ptr_inc(r_wptr);
            if (w_pop)
                r_rptr <= ptr_inc(r_rptr);
            r_count <= w_count_nxt;
        end
    end

    // ---------------------------------------------------------- burst engine
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_head_elig)            w_state_nxt = ST_BURST;
            ST_BURST: if (w_last && !w_head_elig) w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_is_wr_nxt = r_is_wr;
        w_rank_nxt  = r_rank;
        w_bg_nxt    = r_bg;
        w_ba_nxt    = r_ba;
        w_col_nxt   = r_col;
        if (w_pop) begin
            w_is_wr_nxt = r_q_wr[r_rptr];
            w_rank_nxt  = r_q_rank[r_rptr];
            w_bg_nxt    = r_q_bg[r_rptr];
            w_ba_nxt    = r_q_ba[r_rptr];
            w_col_nxt   = r_q_col[r_rptr];
        end
        w_burst_nxt = (w_state_nxt == ST_BURST);
        w_beat_nxt  = '0;
        if (w_burst_nxt && !w_pop)
            w_beat_nxt = r_beat + 1'b1;
        // Sequential order wraps inside the BL-aligned column block.
        w_bcol_nxt   = {w_col_nxt[COLWIDTH-1:BLW], w_col_nxt[BLW-1:0] + w_beat_nxt};
        w_rd_oe_nxt  = w_burst_nxt && !w_is_wr_nxt;
        w_wr_cap_nxt = w_burst_nxt && w_is_wr_nxt;
        w_dqs_nxt    = w_burst_nxt && !w_beat_nxt[0];
        w_busy_nxt   = (w_count_nxt != '0) || w_burst_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat     <= '0;
            r_is_wr    <= 1'b0;
            r_rank     <= '0;
            r_bg       <= '0;
            r_ba       <= '0;
            r_col      <= '0;
            r_bcol     <= '0;
            r_rd_oe    <= 1'b0;
            r_wr_cap   <= 1'b0;
            r_dqs      <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_late     <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_beat     <= w_beat_nxt;
            r_is_wr    <= w_is_wr_nxt;
            r_rank     <= w_rank_nxt;
            r_bg       <= w_bg_nxt;
            r_ba       <= w_ba_nxt;
            r_col      <= w_col_nxt;
            r_bcol     <= w_bcol_nxt;
            r_rd_oe    <= w_rd_oe_nxt;
            r_wr_cap   <= w_wr_cap_nxt;
            r_dqs      <= w_dqs_nxt;
            r_busy     <= w_busy_nxt;
            r_overflow <= r_overflow | w_ovf;
            r_late     <= r_late | w_late;
            r_cmd_err  <= r_cmd_err | w_cmd_err;
        end
    end

    assign rd_oe      = r_rd_oe;
    assign wr_cap     = r_wr_cap;
    assign beat       = r_beat;
    assign dqs_t_o    = r_dqs;
    assign burst_rank = r_rank;
    assign burst_bg   = r_bg;
    assign burst_ba   = r_ba;
    assign burst_col  = r_bcol;
    assign q_count    = r_count;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign late       = r_late;
    assign cmd_err    = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_burst_sequencer
// Brief    : Directed self-checking bench for ddr_burst_sequencer (RANKS=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_burst_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] cs_n = 2'b11;
    logic       rd = 1'b0, wr = 1'b0;
    logic [1:0] bg = '0, ba = '0;
    logic [9:0] col = '0;
    logic       rd_oe, wr_cap, dqs_t_o, busy, overflow, late, cmd_err;
    logic [2:0] beat;
    logic [0:0] burst_rank;
    logic [1:0] burst_bg, burst_ba;
    logic [9:0] burst_col;
    logic [2:0] q_count;

    int errors = 0;
    int checks = 0;

    ddr_burst_sequencer #(
        .RANKS(2), .BGWIDTH(2), .BAWIDTH(2), .COLWIDTH(10),
        .BL(8), .CL(16), .CWL(12), .QDEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd(rd), .wr(wr),
        .bg(bg), .ba(ba), .col(col),
        .rd_oe(rd_oe), .wr_cap(wr_cap), .beat(beat), .dqs_t_o(dqs_t_o),
        .burst_rank(burst_rank), .burst_bg(burst_bg), .burst_ba(burst_ba),
        .burst_col(burst_col), .q_count(q_count), .busy(busy),
        .overflow(overflow), .late(late), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n active edges, returning at the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic r, input logic w, input logic [1:0] cs,
                         input logic [1:0] g, input logic [1:0] b, input logic [9:0] c);
        rd = r; wr = w; cs_n = cs; bg = g; ba = b; col = c;
        tick(1);
        rd = 1'b0; wr = 1'b0; cs_n = 2'b11;
    endtask

    initial begin
        logic [9:0] wrap_tbl [8];
        int n_hi, n_b;
        wrap_tbl = '{10'h3FE, 10'h3FF, 10'h3F8, 10'h3F9, 10'h3FA, 10'h3FB, 10'h3FC, 10'h3FD};

        #1 reset = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_rd_oe", 32'(rd_oe), 0);
        chk("rst_wr_cap", 32'(wr_cap), 0);
        chk("rst_beat", 32'(beat), 0);
        chk("rst_dqs", 32'(dqs_t_o), 0);
        chk("rst_q_count", 32'(q_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {29'd0, overflow, late, cmd_err}, 0);
        chk("rst_burst_col", 32'(burst_col), 0);
        reset = 1'b0;

        // Single read, col 0x010, bg 2, ba 1, rank 0
        issue(1'b1, 1'b0, 2'b10, 2'd2, 2'd1, 10'h010);
        chk("rd1_q_count", 32'(q_count), 1);
        chk("rd1_busy", 32'(busy), 1);
        tick(15);
        chk("rd1_pre_oe", 32'(rd_oe), 0);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("rd1_oe", 32'(rd_oe), 1);
            chk("rd1_wr_cap", 32'(wr_cap), 0);
            chk("rd1_beat", 32'(beat), 32'(k));
            chk("rd1_col", 32'(burst_col), 32'h010 + 32'(k));
            chk("rd1_dqs", 32'(dqs_t_o), (k % 2 == 0) ? 1 : 0);
        end
        chk("rd1_bg", 32'(burst_bg), 2);
        chk("rd1_ba", 32'(burst_ba), 1);
        chk("rd1_rank", 32'(burst_rank), 0);
        chk("rd1_q_after_pop", 32'(q_count), 0);
        tick(1);
        chk("rd1_end_oe", 32'(rd_oe), 0);
        chk("rd1_end_busy", 32'(busy), 0);
        chk("rd1_late", 32'(late), 0);

        // Wrap order inside the 8-aligned block
        issue(1'b1, 1'b0, 2'b10, 2'd0, 2'd0, 10'h3FE);
        tick(15);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("wrap_col", 32'(burst_col), 32'(wrap_tbl[k]));
        end
        tick(1);
        chk("wrap_end_busy", 32'(busy), 0);

        // Writes at edges 0 and 8: gapless 16 beats
        issue(1'b0, 1'b1, 2'b10, 2'd0, 2'd0, 10'h100);
        tick(7);
        issue(1'b0, 1'b1, 2'b10, 2'd0, 2'd0, 10'h108);
        chk("b2b_q_count", 32'(q_count), 2);
        tick(3);
        chk("b2b_pre_cap", 32'(wr_cap), 0);
        for (int k = 12; k < 28; k++) begin
            tick(1);
            chk("b2b_wr_cap", 32'(wr_cap), 1);
            chk("b2b_rd_oe", 32'(rd_oe), 0);
            chk("b2b_beat", 32'(beat), 32'((k - 12) % 8));
        end
        tick(1);
        chk("b2b_end_cap", 32'(wr_cap), 0);
        chk("b2b_late", 32'(late), 0);

        // Writes at edges 0 and 4: second deferred to edge 20, late set
        issue(1'b0, 1'b1, 2'b10, 2'd0, 2'd0, 10'h000);
        tick(3);
        issue(1'b0, 1'b1, 2'b10, 2'd0, 2'd0, 10'h040);
        tick(11);
        chk("tccd_late_before", 32'(late), 0);
        tick(1);
        chk("tccd_late_set", 32'(late), 1);
        tick(3);
        chk("tccd_first_last_beat", 32'(beat), 7);
        tick(1);
        chk("tccd_second_beat0", 32'(beat), 0);
        chk("tccd_second_cap", 32'(wr_cap), 1);
        chk("tccd_second_col", 32'(burst_col), 32'h040);
        tick(8);
        chk("tccd_end_busy", 32'(busy), 0);

        // Five reads on consecutive edges into a 4-deep queue
        for (int k = 0; k < 5; k++) begin
            issue(1'b1, 1'b0, 2'b10, 2'd0, 2'd0, 10'(k * 8));
            if (k == 3) chk("ovf_q_peak", 32'(q_count), 4);
        end
        chk("ovf_q_full", 32'(q_count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        n_hi = 0; n_b = 0;
        for (int k = 0; k < 56; k++) begin
            tick(1);
            if (rd_oe) n_hi++;
            if (rd_oe && beat == 3'd0) n_b++;
        end
        chk("ovf_beats", 32'(n_hi), 32);
        chk("ovf_bursts", 32'(n_b), 4);
        chk("ovf_q_drained", 32'(q_count), 0);

        // Rank decode and illegal commands
        issue(1'b1, 1'b0, 2'b11, 2'd0, 2'd0, 10'h000);
        chk("nocs_q_count", 32'(q_count), 0);
        chk("nocs_cmd_err", 32'(cmd_err), 0);
        issue(1'b1, 1'b0, 2'b00, 2'd0, 2'd0, 10'h000);
        chk("multics_cmd_err", 32'(cmd_err), 1);
        chk("multics_q_count", 32'(q_count), 0);
        n_hi = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (rd_oe || wr_cap || busy) n_hi++;
        end
        chk("multics_no_burst", 32'(n_hi), 0);
        issue(1'b1, 1'b1, 2'b10, 2'd0, 2'd0, 10'h000);
        chk("rdwr_q_count", 32'(q_count), 0);
        issue(1'b1, 1'b0, 2'b01, 2'd3, 2'd2, 10'h020);
        tick(16);
        chk("rank1_oe", 32'(rd_oe), 1);
        chk("rank1_rank", 32'(burst_rank), 1);
        chk("rank1_bg", 32'(burst_bg), 3);
        tick(8);
        chk("rank1_end_busy", 32'(busy), 0);

        // Reset during beat 3 with a second read still queued
        issue(1'b1, 1'b0, 2'b10, 2'd1, 2'd1, 10'h080);
        tick(7);
        issue(1'b1, 1'b0, 2'b10, 2'd1, 2'd1, 10'h088);
        tick(11);
        chk("mid_beat3", 32'(beat), 3);
        chk("mid_q_count", 32'(q_count), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rd_oe", 32'(rd_oe), 0);
        chk("mid_rst_beat", 32'(beat), 0);
        chk("mid_rst_q_count", 32'(q_count), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_flags", {29'd0, overflow, late, cmd_err}, 0);
        chk("mid_rst_target", {20'd0, burst_bg, burst_ba, burst_col}, 0);
        @(negedge clk);
        reset = 1'b0;
        issue(1'b1, 1'b0, 2'b10, 2'd0, 2'd0, 10'h055);
        chk("post_rst_q_count", 32'(q_count), 1);
        n_hi = 0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (rd_oe) n_hi++;
        end
        chk("post_rst_stale_quiet", 32'(n_hi), 0);
        tick(1);
        chk("post_rst_oe", 32'(rd_oe), 1);
        chk("post_rst_col0", 32'(burst_col), 32'h055);
        tick(1);
        chk("post_rst_col1", 32'(burst_col), 32'h056);
        tick(7);
        chk("post_rst_end_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
